jump_sequencer: RTL



---
 rtl/jump_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/jump_sequencer.sv
// Micro-program sequencer: drives the jump-condition mux select and computes the next upc.
// Optional WAIT timeout escape is enabled by defining JUMP_SEQ_WAIT_TIMEOUT_EN.
module jump_sequencer #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        op,
  input  logic [1:0]        cond_sel,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              force_load,
  input  logic [ADDR_W-1:0] force_addr,
  output logic [1:0]        seleccion,
  input  logic              cond_y,
  output logic [ADDR_W-1:0] upc,
  output logic              jumped,
  output logic              timeout
);

  localparam logic [1:0] OpCont  = 2'b00;
  localparam logic [1:0] OpJmp   = 2'b01;
  localparam logic [1:0] OpJcond = 2'b10;
  localparam logic [1:0] OpWait  = 2'b11;
  localparam logic [ADDR_W-1:0] AddrOne = 1;

  typedef enum logic [1:0] {
    StIdle,
    StEval,
    StWait
  } state_e;

  state_e            r_state;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_upc;
  logic [1:0]        r_sel;
  logic              r_jumped;
  logic              w_accept;
  logic [ADDR_W-1:0] w_upc_inc;

`ifdef JUMP_SEQ_WAIT_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CntW-1:0] CntOne  = 1;
  // Count value seen during the TIMEOUT_CYC-th cycle spent in EVAL+WAIT.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] r_cnt;
  logic            r_timeout;
`endif

  // A forced load blocks acceptance in the same cycle.
  assign instr_ready = (r_state == StIdle) && !force_load;
  assign w_accept    = instr_valid && instr_ready;
  assign w_upc_inc   = r_upc + AddrOne;

  assign upc       = r_upc;
  assign seleccion = r_sel;
  assign jumped    = r_jumped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_op     <= OpCont;
      r_addr   <= '0;
      r_upc    <= '0;
      r_sel    <= 2'b00;
      r_jumped <= 1'b0;
`ifdef JUMP_SEQ_WAIT_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_jumped <= 1'b0;
`ifdef JUMP_SEQ_WAIT_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      if (force_load) begin
        r_upc   <= force_addr;
        r_state <= StIdle;
        r_op    <= OpCont;
      end else begin
        case (r_state)
          StIdle: begin
            if (w_accept) begin
              case (op)
                OpCont: r_upc <= w_upc_inc;
                OpJmp: begin
                  r_upc    <= jump_addr;
                  r_jumped <= 1'b1;
                end
                default: begin
                  r_op    <= op;
                  r_addr  <= jump_addr;
                  r_sel   <= cond_sel;
                  r_state <= StEval;
`ifdef JUMP_SEQ_WAIT_TIMEOUT_EN
                  r_cnt   <= '0;
`endif
                end
              endcase
            end
          end
          StEval: begin
            if (r_op == OpJcond) begin
              if (cond_y) begin
                r_upc    <= r_addr;
                r_jumped <= 1'b1;
              end else begin
                r_upc <= w_upc_inc;
              end
              r_state <= StIdle;
            end else if (cond_y) begin
              r_upc   <= w_upc_inc;
              r_state <= StIdle;
            end else begin
              r_state <= StWait;
`ifdef JUMP_SEQ_WAIT_TIMEOUT_EN
              r_cnt   <= r_cnt + CntOne;
`endif
            end
          end
          StWait: begin
            if (cond_y) begin
              r_upc   <= w_upc_inc;
              r_state <= StIdle;
`ifdef JUMP_SEQ_WAIT_TIMEOUT_EN
            end else if (r_cnt == CntLast) begin
              r_upc     <= r_addr;
              r_jumped  <= 1'b1;
              r_timeout <= 1'b1;
              r_state   <= StIdle;
            end else begin
              r_cnt <= r_cnt + CntOne;
`endif
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

`ifdef JUMP_SEQ_WAIT_TIMEOUT_EN
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

endmodule
